// File: rtl/cc1200_pkg.sv
// Shared constants and gate-state encoding for the CC1200 transmit sample path.
package cc1200_pkg;

   localparam int SAMPLE_W      = 12;
   localparam int DEPTH_DEFAULT = 256;

   typedef enum logic [1:0] {
      GATE_IDLE  = 2'd0,
      GATE_ARMED = 2'd1,
      GATE_SEND  = 2'd2
   } gate_state_t;

endpackage

// File: rtl/cc1200_sfifo_mem.sv
// DEPTH x DATA_W simple dual-port sample store: synchronous write, registered
// read-before-write output.
module cc1200_sfifo_mem
   import cc1200_pkg::*;
#(
   parameter int DATA_W = SAMPLE_W,
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/cc1200_tx_sample_fifo.sv
// FWFT sample FIFO feeding the CC1200 GetDataEn/GetData/Next_data interface,
// with a packet gate. Optional counters under CC1200_TXFIFO_STATS_EN.
module cc1200_tx_sample_fifo
   import cc1200_pkg::*;
#(
   parameter int DATA_W = SAMPLE_W,
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              flush,
   input  logic [ADDR_W:0]   pkt_thresh,
   output logic              get_data_en,
   output logic [DATA_W-1:0] get_data,
   input  logic              next_data,
   output logic [ADDR_W:0]   level,
   output logic              underflow
`ifdef CC1200_TXFIFO_STATS_EN
   ,
   output logic [15:0]       drop_cnt,
   output logic [15:0]       pkt_cnt_total
`endif
);

   localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_addr;
   logic [ADDR_W:0]   level_q;
   logic              push, pop;
   logic              byp_sel;
   logic [DATA_W-1:0] byp_data, rd_q;
   gate_state_t       state, state_nxt;
   logic [ADDR_W:0]   thr_q, thr_nxt, pkt_cnt, pkt_cnt_nxt;
   logic              pkt_done;

   assign in_ready = (level_q != FULL_LVL);
   assign push     = in_valid && in_ready;
   assign pop      = next_data && (level_q != '0);
   assign rd_addr  = pop ? rd_ptr + ADDR_W'(1) : rd_ptr;
   assign level    = level_q;

   cc1200_sfifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push && !flush),
      .wr_addr (wr_ptr),
      .wr_data (in_data),
      .rd_addr (rd_addr),
      .rd_data (rd_q)
   );

   // The registered read misses a sample written the same cycle it becomes
   // head, so that sample is carried in a one-cycle bypass register.
   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level_q  <= '0;
         byp_sel  <= 1'b0;
         byp_data <= '0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + ADDR_W'(1);
            byp_data <= in_data;
         end
         if (pop) begin
            rd_ptr <= rd_addr;
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + (ADDR_W+1)'(1);
            2'b01:   level_q <= level_q - (ADDR_W+1)'(1);
            default: level_q <= level_q;
         endcase
         byp_sel <= push && (wr_ptr == rd_addr);
      end
   end

   assign get_data = (level_q == '0) ? '0 : (byp_sel ? byp_data : rd_q);

   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         underflow <= 1'b0;
      end else if (next_data && (level_q == '0)) begin
         underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         state   <= GATE_IDLE;
         thr_q   <= '0;
         pkt_cnt <= '0;
      end else begin
         state   <= state_nxt;
         thr_q   <= thr_nxt;
         pkt_cnt <= pkt_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      thr_nxt     = thr_q;
      pkt_cnt_nxt = pkt_cnt;
      pkt_done    = 1'b0;
      case (state)
         GATE_IDLE: begin
            if ((pkt_thresh != '0) && (pkt_thresh <= FULL_LVL) && (level_q >= pkt_thresh)) begin
               thr_nxt     = pkt_thresh;
               pkt_cnt_nxt = '0;
               state_nxt   = GATE_ARMED;
            end
         end
         GATE_ARMED: begin
            if (pop) begin
               pkt_cnt_nxt = (ADDR_W+1)'(1);
               if (thr_q == (ADDR_W+1)'(1)) begin
                  state_nxt = GATE_IDLE;
                  pkt_done  = 1'b1;
               end else begin
                  state_nxt = GATE_SEND;
               end
            end
         end
         GATE_SEND: begin
            if (pop) begin
               pkt_cnt_nxt = pkt_cnt + (ADDR_W+1)'(1);
               if (pkt_cnt_nxt == thr_q) begin
                  state_nxt = GATE_IDLE;
                  pkt_done  = 1'b1;
               end
            end
         end
         default: state_nxt = GATE_IDLE;
      endcase
   end

   assign get_data_en = (state != GATE_IDLE);

`ifdef CC1200_TXFIFO_STATS_EN
   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         drop_cnt      <= '0;
         pkt_cnt_total <= '0;
      end else begin
         if (in_valid && !in_ready && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
         if (pkt_done) begin
            pkt_cnt_total <= pkt_cnt_total + 16'd1;
         end
      end
   end
`else
   logic unused_done;
   assign unused_done = pkt_done;
`endif

endmodule

// File: doc/cc1200_tx_sample_fifo.md
Name: cc1200_tx_sample_fifo

Overview:
- Sample buffer directly upstream of the CC1200 SPI transmit path.
- Accepts 12-bit samples from the data source and stores them in a single-clock FIFO with first-word-fall-through reads.
- Drives the transmitter's GetDataEn / GetData / Next_data interface.
- Raises get_data_en only when a full packet's worth of samples is buffered, then keeps it up until exactly that many samples have been popped.

Parameters:
DATA_W, 12, sample width.
DEPTH, 256, FIFO depth in samples; must be a power of two ≥ 4.
ADDR_W, $clog2(DEPTH), pointer width (derived).

Ports:
clk  input  1  system clock
rstn  input  1  reset, synchronous, active-low
in_valid  input  1  source sample strobe
in_data  input  DATA_W  source sample
in_ready  output  1  FIFO can accept a sample this cycle
flush  input  1  synchronous clear of contents and gate state
pkt_thresh  input  ADDR_W+1  samples per packet
get_data_en  output  1  packet available (to GetDataEn)
get_data  output  DATA_W  head sample (to GetData)
next_data  input  1  pop strobe (from Next_data)
level  output  ADDR_W+1  current occupancy
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Interface decision: one clock, clk; reset rstn is synchronous and active-low. All state clears on the clk edge when rstn=0.
- Reset values: level=0, in_ready=1, get_data_en=0, get_data=0, underflow=0, gate state=IDLE.
- Push rule: a push occurs when in_valid && in_ready. in_ready = (level != DEPTH).
- Pop rule: a pop occurs when next_data && (level != 0).
- Pointers: wrap modulo DEPTH.
- Occupancy: level updates the cycle after push/pop. Simultaneous push and pop leaves level unchanged.
- Pop while empty: ignored and sets underflow.
- Push/pop at empty: a simultaneous push+pop while empty performs the push only; the pop counts as an underflow.
- Push at full: in_valid while full is dropped; no error flag.
- get_data (FWFT):
  - Registered head.
  - Valid whenever level != 0, and equals 0 when empty.
  - After a pop, it shows the next sample on the following cycle.
  - The first sample written into an empty FIFO appears on get_data 1 cycle after the push.
- flush:
  - Has priority over push, pop and the gate FSM.
  - Next cycle: level=0, get_data=0, state=IDLE, get_data_en=0.
  - underflow is cleared by flush and by reset only.
- Gate FSM (pkt_cnt is an internal ADDR_W+1 counter; thr_q is pkt_thresh latched at arming):
  - IDLE: when pkt_thresh != 0, pkt_thresh ≤ DEPTH and level ≥ pkt_thresh → latch thr_q, go to ARMED. Otherwise stay.
  - ARMED: get_data_en=1. On the first pop, pkt_cnt=1 and go to SEND. If thr_q==1, go straight back to IDLE instead.
  - SEND: get_data_en=1. Each pop increments pkt_cnt. When the pop makes pkt_cnt==thr_q, get_data_en drops on the next cycle and the FSM returns to IDLE.
  - Re-arming requires a fresh IDLE evaluation, so there is at least 1 cycle of get_data_en=0 between packets.
- pkt_thresh changes while ARMED/SEND have no effect until the next IDLE.
- Out-of-range pkt_thresh: 0 or > DEPTH never arms.

Optional Feature:
- Macro: CC1200_TXFIFO_STATS_EN.
- Defined:
  - Adds output drop_cnt [15:0], counting pushes rejected because the FIFO was full; saturates at 16'hFFFF.
  - Adds output pkt_cnt_total [15:0], counting completed packets (SEND/ARMED→IDLE on the final pop); wraps.
  - Both clear on rstn and flush.
- Not defined: neither port exists, and no counter logic is built.

Decomposition:
- Shared package cc1200_pkg holds:
  - SAMPLE_W=12;
  - gate state enum {GATE_IDLE, GATE_ARMED, GATE_SEND} as 2-bit constants;
  - the DEPTH default.
- One sub-module: cc1200_sfifo_mem, a DEPTH×DATA_W simple dual-port array with synchronous write and registered read.
- Top-level logic: pointers, level, FWFT head and gate FSM.

Test Plan:
- Arm/drain: reset, pkt_thresh=6; push 5 samples 0x001..0x005 → get_data_en stays 0. Push 0x006 → get_data_en=1 within 2 cycles and get_data=0x001. Pop 6 times → get_data=0x002..0x006 in order, then get_data_en=0, level=0.
- Full: push 256 samples → in_ready=0, level=256. The 257th push (0xABC) is dropped. Pop all → last get_data=sample 256, not 0xABC.
- Underflow: next_data on an empty FIFO → underflow=1 and level stays 0. Then a simultaneous push 0x123 and pop while empty → level=1, get_data=0x123.
- Flush mid-packet: pkt_thresh=4, 8 samples buffered, 2 popped (SEND) → flush → next cycle level=0, get_data_en=0, underflow=0. Push 4 more → re-arms with the first new sample at the head.
- Wrap and thresholds: stream 1000 samples with random push/pop and pkt_thresh=0 → get_data_en never 1, and order is preserved across pointer wrap. Then pkt_thresh=257 with 256 buffered → never arms.
- Stats (macro defined): 3 pushes while full → drop_cnt=3; two completed packets of 4 → pkt_cnt_total=2. flush → both 0.
